// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the 5-bit-opcode CPU datapath. It shares one ALU and one
// memory port across the instruction steps and stalls on the mem_ready handshake.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE  = 4'd0,
  parameter bit         ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [4:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       run,
  output logic       pcwrite,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned ST_W  = 4;
  localparam int unsigned ALU_W = 3;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00001;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00010;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00011;
  localparam logic [OP_W-1:0] OP_SLT  = 5'b00100;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01000;
  localparam logic [OP_W-1:0] OP_LW   = 5'b10000;
  localparam logic [OP_W-1:0] OP_SW   = 5'b10001;
  localparam logic [OP_W-1:0] OP_BEQ  = 5'b11000;
  localparam logic [OP_W-1:0] OP_J    = 5'b11100;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  state_t           state_q, state_d;
  logic             is_rtype;
  logic [ALU_W-1:0] rtype_alu;

  // Register-register opcode class and its ALU function
  always_comb begin
    is_rtype  = 1'b1;
    rtype_alu = ALU_ADD;
    unique case (op)
      OP_ADD:  rtype_alu = ALU_ADD;
      OP_SUB:  rtype_alu = ALU_SUB;
      OP_AND:  rtype_alu = ALU_AND;
      OP_OR:   rtype_alu = ALU_OR;
      OP_SLT:  rtype_alu = ALU_SLT;
      default: is_rtype  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= state_t'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath controls; reset forces every control to its idle value
  always_comb begin
    state_d    = state_q;
    pcwrite    = 1'b0;
    pcsrc      = 2'b00;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    illegal    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (run) begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        if (op == OP_LW || op == OP_SW) begin
          state_d = S_MEMADR;
        end else if (is_rtype) begin
          state_d = S_REXEC;
        end else if (op == OP_ADDI) begin
          state_d = S_IEXEC;
        end else if (op == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (op == OP_J) begin
          state_d = S_JUMP;
        end else begin
          illegal = 1'b1;
          state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_REXEC: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
        state_d    = S_RWB;
      end
      S_RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcwrite    = zero;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Asynchronous reset must kill any in-flight memory request without waiting for a clock
    if (!nreset) begin
      pcwrite    = 1'b0;
      pcsrc      = 2'b00;
      iord       = 1'b0;
      memread    = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      alucontrol = ALU_ADD;
      illegal    = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: trapping and non-trapping instances share stimulus and
// are compared every cycle against an instruction-sequence model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [4:0] op = 5'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       run = 1'b0;

  always #5 clk = ~clk;

  logic       pcwrite0, iord0, memread0, memwrite0, irwrite0, regdst0, memtoreg0;
  logic       regwrite0, alusrca0, illegal0;
  logic [1:0] pcsrc0, alusrcb0;
  logic [2:0] alucontrol0;
  logic [3:0] state0;
  logic       pcwrite1, iord1, memread1, memwrite1, irwrite1, regdst1, memtoreg1;
  logic       regwrite1, alusrca1, illegal1;
  logic [1:0] pcsrc1, alusrcb1;
  logic [2:0] alucontrol1;
  logic [3:0] state1;

  multicycle_controller #(.RESET_STATE(4'd0), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .nreset(nreset), .op(op), .zero(zero), .mem_ready(mem_ready), .run(run),
    .pcwrite(pcwrite0), .pcsrc(pcsrc0), .iord(iord0), .memread(memread0),
    .memwrite(memwrite0), .irwrite(irwrite0), .regdst(regdst0), .memtoreg(memtoreg0),
    .regwrite(regwrite0), .alusrca(alusrca0), .alusrcb(alusrcb0),
    .alucontrol(alucontrol0), .illegal(illegal0), .state(state0)
  );

  multicycle_controller #(.RESET_STATE(4'd0), .ILLEGAL_TRAP(1'b0)) dut_nt (
    .clk(clk), .nreset(nreset), .op(op), .zero(zero), .mem_ready(mem_ready), .run(run),
    .pcwrite(pcwrite1), .pcsrc(pcsrc1), .iord(iord1), .memread(memread1),
    .memwrite(memwrite1), .irwrite(irwrite1), .regdst(regdst1), .memtoreg(memtoreg1),
    .regwrite(regwrite1), .alusrca(alusrca1), .alusrcb(alusrcb1),
    .alucontrol(alucontrol1), .illegal(illegal1), .state(state1)
  );

  logic [20:0] act0, act1;
  assign act0 = {pcwrite0, pcsrc0, iord0, memread0, memwrite0, irwrite0, regdst0, memtoreg0,
                 regwrite0, alusrca0, alusrcb0, alucontrol0, illegal0, state0};
  assign act1 = {pcwrite1, pcsrc1, iord1, memread1, memwrite1, irwrite1, regdst1, memtoreg1,
                 regwrite1, alusrca1, alusrcb1, alucontrol1, illegal1, state1};

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // States an instruction walks through after DECODE; 0 means the instruction is complete
  function automatic int seq_at(input logic [4:0] o, input bit trap, input int k);
    int s[$];
    case (o)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4: s = {6, 7};
      5'd8:  s = {8, 9};
      5'd16: s = {2, 3, 4};
      5'd17: s = {2, 5};
      5'd24: s = {10};
      5'd28: s = {11};
      default: if (trap) s = {12}; else s = {};
    endcase
    return (k < s.size()) ? s[k] : 0;
  endfunction

  function automatic logic [2:0] alu_of(input logic [4:0] o);
    logic [2:0] tbl[5];
    tbl = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    return (o < 5'd5) ? tbl[o] : 3'b010;
  endfunction

  function automatic bit legal_op(input logic [4:0] o);
    return o inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd16, 5'd17, 5'd24, 5'd28};
  endfunction

  function automatic logic [20:0] exp_vec(input int st, input logic [4:0] o, input logic r,
                                          input logic mr, input logic z, input logic rst_n);
    logic pcw, io, mrd, mwr, irw, rdst, m2r, rw, srca, ill;
    logic [1:0] psrc, srcb;
    logic [2:0] alu;
    {pcw, io, mrd, mwr, irw, rdst, m2r, rw, srca, ill} = '0;
    psrc = 2'b00; srcb = 2'b00; alu = 3'b010;
    if (rst_n) begin
      case (st)
        0:  if (r) begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
        1:  begin srcb = 2'b11; ill = !legal_op(o); end
        2:  begin srca = 1'b1; srcb = 2'b10; end
        3:  begin io = 1'b1; mrd = 1'b1; end
        4:  begin rw = 1'b1; m2r = 1'b1; end
        5:  begin io = 1'b1; mwr = 1'b1; end
        6:  begin srca = 1'b1; alu = alu_of(o); end
        7:  begin rw = 1'b1; rdst = 1'b1; end
        8:  begin srca = 1'b1; srcb = 2'b10; end
        9:  rw = 1'b1;
        10: begin srca = 1'b1; alu = 3'b110; psrc = 2'b01; pcw = z; end
        11: begin psrc = 2'b10; pcw = 1'b1; end
        default: ;
      endcase
    end
    return {pcw, psrc, io, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, alu, ill, 4'(st)};
  endfunction

  int m_st[2] = '{0, 0};
  int m_k[2]  = '{0, 0};

  // Model: index 0 traps on illegal opcodes, index 1 does not
  always @(posedge clk or negedge nreset) begin
    for (int i = 0; i < 2; i++) begin
      if (!nreset) begin
        m_st[i] <= 0;
        m_k[i]  <= 0;
      end else if (m_st[i] == 0) begin
        if (run && mem_ready) m_st[i] <= 1;
      end else if (m_st[i] == 12) begin
        m_st[i] <= 12;
      end else if ((m_st[i] == 3 || m_st[i] == 5) && !mem_ready) begin
        m_st[i] <= m_st[i];
      end else if (m_st[i] == 1) begin
        m_k[i]  <= 0;
        m_st[i] <= seq_at(op, i == 0, 0);
      end else begin
        m_k[i]  <= m_k[i] + 1;
        m_st[i] <= seq_at(op, i == 0, m_k[i] + 1);
      end
    end
  end

  always begin
    @(negedge clk);
    #3;
    check("trap_inst_outputs", 32'(act0), 32'(exp_vec(m_st[0], op, run, mem_ready, zero, nreset)));
    check("notrap_inst_outputs", 32'(act1), 32'(exp_vec(m_st[1], op, run, mem_ready, zero, nreset)));
  end

  // Runs one instruction from FETCH back to FETCH with the given mem_ready stall counts
  task automatic run_instr(input string name, input logic [4:0] o, input logic z,
                           input int fw, input int mw, input int exp_cyc, input int exp_pcw,
                           input int exp_rw, input int exp_mw);
    int cyc = 0, fc = 0, mc = 0, nir = 0, npc = 0, nrw = 0, nmw = 0;
    bit left = 0;
    op = o; zero = z; run = 1'b1;
    while (1) begin
      if (m_st[0] == 0 && fc < fw) begin
        mem_ready = 1'b0; fc++;
      end else if ((m_st[0] == 3 || m_st[0] == 5) && mc < mw) begin
        mem_ready = 1'b0; mc++;
      end else begin
        mem_ready = 1'b1;
      end
      #2;
      nir += int'(irwrite0); npc += int'(pcwrite0);
      nrw += int'(regwrite0); nmw += int'(memwrite0);
      @(negedge clk);
      cyc++;
      if (m_st[0] != 0) left = 1;
      if ((left && m_st[0] == 0) || cyc >= 50) break;
    end
    run = 1'b0; mem_ready = 1'b1;
    check({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({name, "_irwrite_count"}, 32'(nir), 32'd1);
    check({name, "_pcwrite_count"}, 32'(npc), 32'(exp_pcw));
    check({name, "_regwrite_count"}, 32'(nrw), 32'(exp_rw));
    check({name, "_memwrite_count"}, 32'(nmw), 32'(exp_mw));
  endtask

  initial begin
    int n_ill0, n_ill1;
    bit hit;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 32'(state0), 32'd0);
    check("reset_enables", 32'({pcwrite0, memread0, memwrite0, irwrite0, regwrite0}), 32'd0);
    check("reset_alucontrol", 32'(alucontrol0), 32'd2);
    @(negedge clk);
    nreset = 1'b1;

    repeat (5) @(negedge clk);
    #1;
    check("idle_memread", 32'(memread0), 32'd0);
    check("idle_state", 32'(state0), 32'd0);
    @(negedge clk);

    //        name     op      z   fw mw cyc pcw rw mw
    run_instr("add",   5'd0,  1'b0, 0, 0, 4,  1,  1, 0);
    run_instr("sub",   5'd1,  1'b0, 0, 0, 4,  1,  1, 0);
    run_instr("slt",   5'd4,  1'b0, 0, 0, 4,  1,  1, 0);
    run_instr("or_st", 5'd3,  1'b0, 1, 0, 5,  1,  1, 0);
    run_instr("addi",  5'd8,  1'b0, 0, 0, 4,  1,  1, 0);
    run_instr("lw",    5'd16, 1'b0, 0, 0, 5,  1,  1, 0);
    run_instr("lw_st", 5'd16, 1'b0, 2, 3, 10, 1,  1, 0);
    run_instr("beq_t", 5'd24, 1'b1, 0, 0, 3,  2,  0, 0);
    run_instr("beq_n", 5'd24, 1'b0, 0, 0, 3,  1,  0, 0);
    run_instr("sw",    5'd17, 1'b0, 0, 0, 4,  1,  0, 1);
    run_instr("sw_st", 5'd17, 1'b0, 0, 2, 6,  1,  0, 3);
    run_instr("j",     5'd28, 1'b0, 0, 0, 3,  2,  0, 0);

    // Reset asserted between clock edges while a load is waiting in MEMRD
    op = 5'd16; run = 1'b1; mem_ready = 1'b1; hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (m_st[0] == 3) begin
        hit = 1; mem_ready = 1'b0; run = 1'b0;
      end
    end
    #1;
    check("memrd_active", 32'({state0, memread0}), 32'({4'd3, 1'b1}));
    #1;
    nreset = 1'b0;
    #1;
    check("async_rst_memread", 32'(memread0), 32'd0);
    check("async_rst_state", 32'(state0), 32'd0);
    @(negedge clk);
    nreset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_state", 32'(state0), 32'd0);
    check("post_rst_enables", 32'({pcwrite0, memread0, memwrite0, irwrite0, regwrite0}), 32'd0);
    @(negedge clk);

    op = 5'b11111; run = 1'b1; mem_ready = 1'b1;
    n_ill0 = 0; n_ill1 = 0;
    repeat (6) begin
      #2;
      n_ill0 += int'(illegal0);
      n_ill1 += int'(illegal1);
      @(negedge clk);
    end
    #1;
    check("illegal_pulses_trap", 32'(n_ill0), 32'd1);
    check("illegal_pulses_notrap", 32'(n_ill1), 32'd3);
    check("halt_state", 32'(state0), 32'd12);
    check("notrap_back_to_fetch", 32'(state1), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("halt_sticky", 32'(state0), 32'd12);
    run = 1'b0;
    @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    #1;
    check("halt_exit_by_reset", 32'(state0), 32'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
